// File: rtl/neuron_cfg_pkg.sv
// rtl/neuron_cfg_pkg.sv - shared types and constants for the neuron configuration scheduler
//
// Purpose: scheduler state encoding, configuration bus command codes,
//          default widths and the bus tuple type used by the scheduler and its bench.
// Ports:   none (package).
package neuron_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } state_t;

    // Configuration bus commands understood by every neuron.
    localparam int CMD_CLEAR = 0;
    localparam int CMD_W1    = 1;
    localparam int CMD_W2    = 2;
    localparam int CMD_NOP   = 255;

    // Default bus widths; the scheduler uses them as parameter defaults.
    localparam int DEF_ADDR_WIDTH  = 8;
    localparam int DEF_CMD_WIDTH   = 8;
    localparam int DEF_FLOAT_WIDTH = 16;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0]  addr;
        logic [DEF_CMD_WIDTH-1:0]   cmd;
        logic [DEF_FLOAT_WIDTH-1:0] arg;
    } cfg_bus_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-way round-robin arbiter with pointer register
//
// Purpose: grants at most one of two requesters per cycle; on contention the
//          pointer picks the winner, and after any grant the pointer moves to
//          the other port.
// Ports:   clk, rst   - clock, asynchronous active-high reset (pointer -> port 0)
//          en         - arbitration allowed this cycle (no grant when low)
//          req[1:0]   - request per port
//          grant[1:0] - one-hot (or zero) combinational grant
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    // ptr = 0 favours port 0, ptr = 1 favours port 1.
    logic ptr;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req[0] && req[1]) begin
                grant = ptr ? 2'b10 : 2'b01;
            end else begin
                grant = req;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (grant[0]) begin
            ptr <= 1'b1;
        end else if (grant[1]) begin
            ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/neuron_config_scheduler.sv
// rtl/neuron_config_scheduler.sv - configuration bus sequencer, write arbiter and episode evaluator
//
// Purpose: drives the shared neuron configuration bus. In IDLE it forwards
//          weight writes from two requesters (round robin); on an episode
//          request it clears the network, counts output spikes over a window
//          and reports the count and first-spike window index.
// Ports:   clk, rst                    - clock, asynchronous active-high reset
//          reqN_valid/ready/addr/sel/arg - weight write request ports 0 and 1
//          eval_valid/ready, eval_len   - episode start handshake and window length
//          abort                        - cancel running episode (CLEAR/RUN)
//          net_out                      - network output spike
//          bus_addr/bus_cmd/bus_arg     - registered configuration bus
//          res_valid/res_ack            - result handshake
//          res_count/res_first          - spike count and first-spike index
module neuron_config_scheduler
    import neuron_cfg_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int CMD_WIDTH    = DEF_CMD_WIDTH,
    parameter int FLOAT_WIDTH  = DEF_FLOAT_WIDTH,
    parameter int CNT_WIDTH    = 16,
    parameter int WIN_WIDTH    = 16,
    parameter int CLEAR_CYCLES = 2,
    parameter int CMD_NOP      = neuron_cfg_pkg::CMD_NOP,
    parameter logic [ADDR_WIDTH-1:0] ADDR_NONE = {ADDR_WIDTH{1'b1}}
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [ADDR_WIDTH-1:0]  req0_addr,
    input  logic                   req0_sel,
    input  logic [FLOAT_WIDTH-1:0] req0_arg,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [ADDR_WIDTH-1:0]  req1_addr,
    input  logic                   req1_sel,
    input  logic [FLOAT_WIDTH-1:0] req1_arg,
    input  logic                   eval_valid,
    output logic                   eval_ready,
    input  logic [WIN_WIDTH-1:0]   eval_len,
    input  logic                   abort,
    input  logic                   net_out,
    output logic [ADDR_WIDTH-1:0]  bus_addr,
    output logic [CMD_WIDTH-1:0]   bus_cmd,
    output logic [FLOAT_WIDTH-1:0] bus_arg,
    output logic                   res_valid,
    input  logic                   res_ack,
    output logic [CNT_WIDTH-1:0]   res_count,
    output logic [CNT_WIDTH-1:0]   res_first
);

    localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

    state_t state, state_next;

    logic [1:0]             grant;
    logic                   arb_en;
    logic                   eval_accept;
    logic                   clr_last;
    logic                   win_last;
    logic [CLR_W-1:0]       clr_cnt;
    logic [WIN_WIDTH-1:0]   win_idx;
    logic [WIN_WIDTH-1:0]   win_last_idx;
    logic [CNT_WIDTH-1:0]   spike_count;
    logic [CNT_WIDTH-1:0]   first_idx;

    logic [ADDR_WIDTH-1:0]  bus_addr_next;
    logic [CMD_WIDTH-1:0]   bus_cmd_next;
    logic [FLOAT_WIDTH-1:0] bus_arg_next;

    // rst is folded in so every ready is low while reset is held, even
    // though the state register already reads IDLE.
    assign arb_en      = (state == IDLE) && !rst;
    assign eval_ready  = arb_en && !req0_valid && !req1_valid && !res_valid;
    assign eval_accept = eval_valid && eval_ready;

    rr_arbiter_2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (arb_en),
        .req   ({req1_valid, req0_valid}),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    assign clr_last  = (clr_cnt == CLR_W'(CLEAR_CYCLES - 1));
    assign win_last  = (win_idx == win_last_idx);

    assign res_valid = (state == REPORT);
    assign res_count = spike_count;
    assign res_first = first_idx;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (eval_accept) state_next = CLEAR;
            end
            CLEAR: begin
                if (abort)         state_next = IDLE;
                else if (clr_last) state_next = RUN;
            end
            RUN: begin
                if (abort)         state_next = IDLE;
                else if (win_last) state_next = REPORT;
            end
            REPORT: begin
                if (res_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus contents for the next cycle. Decoding from state_next makes the
    // clear command appear in exactly the cycles spent in CLEAR, and makes an
    // abort return the bus to NOP in the same cycle the FSM reaches IDLE.
    always_comb begin
        bus_addr_next = ADDR_NONE;
        bus_cmd_next  = CMD_WIDTH'(CMD_NOP);
        bus_arg_next  = '0;
        if (state_next == CLEAR) begin
            bus_cmd_next = CMD_WIDTH'(CMD_CLEAR);
        end else if (grant[0]) begin
            bus_addr_next = req0_addr;
            bus_cmd_next  = req0_sel ? CMD_WIDTH'(CMD_W2) : CMD_WIDTH'(CMD_W1);
            bus_arg_next  = req0_arg;
        end else if (grant[1]) begin
            bus_addr_next = req1_addr;
            bus_cmd_next  = req1_sel ? CMD_WIDTH'(CMD_W2) : CMD_WIDTH'(CMD_W1);
            bus_arg_next  = req1_arg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_addr <= ADDR_NONE;
            bus_cmd  <= CMD_WIDTH'(CMD_NOP);
            bus_arg  <= '0;
        end else begin
            bus_addr <= bus_addr_next;
            bus_cmd  <= bus_cmd_next;
            bus_arg  <= bus_arg_next;
        end
    end

    // Episode datapath: clear-phase counter, window index and spike statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt      <= '0;
            win_idx      <= '0;
            win_last_idx <= '0;
            spike_count  <= '0;
            first_idx    <= '1;
        end else begin
            // A zero-length request still gets a one-cycle window.
            if (eval_accept) begin
                win_last_idx <= (eval_len == '0) ? '0 : eval_len - WIN_WIDTH'(1);
            end
            case (state)
                CLEAR: begin
                    clr_cnt     <= clr_cnt + CLR_W'(1);
                    win_idx     <= '0;
                    spike_count <= '0;
                    first_idx   <= '1;
                end
                RUN: begin
                    clr_cnt <= '0;
                    win_idx <= win_idx + WIN_WIDTH'(1);
                    if (net_out) begin
                        if (spike_count != '1) begin
                            spike_count <= spike_count + CNT_WIDTH'(1);
                        end
                        if (first_idx == '1) begin
                            first_idx <= CNT_WIDTH'(win_idx);
                        end
                    end
                end
                default: begin
                    clr_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_config_scheduler.sv
// tb/tb_neuron_config_scheduler.sv - self-checking bench for neuron_config_scheduler
module tb_neuron_config_scheduler;
    import neuron_cfg_pkg::*;

    localparam int NCLR = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [7:0]  req0_addr = '0, req1_addr = '0;
    logic        req0_sel = 1'b0, req1_sel = 1'b0;
    logic [15:0] req0_arg = '0, req1_arg = '0;
    logic        eval_valid = 1'b0;
    logic        eval_ready;
    logic [15:0] eval_len = '0;
    logic        abort = 1'b0;
    logic        net_out = 1'b0;
    logic [7:0]  bus_addr;
    logic [7:0]  bus_cmd;
    logic [15:0] bus_arg;
    logic        res_valid;
    logic        res_ack = 1'b0;
    logic [15:0] res_count;
    logic [15:0] res_first;

    always #5 clk = ~clk;

    neuron_config_scheduler #(.CLEAR_CYCLES(NCLR)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_sel   (req0_sel),
        .req0_arg   (req0_arg),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_sel   (req1_sel),
        .req1_arg   (req1_arg),
        .eval_valid (eval_valid),
        .eval_ready (eval_ready),
        .eval_len   (eval_len),
        .abort      (abort),
        .net_out    (net_out),
        .bus_addr   (bus_addr),
        .bus_cmd    (bus_cmd),
        .bus_arg    (bus_arg),
        .res_valid  (res_valid),
        .res_ack    (res_ack),
        .res_count  (res_count),
        .res_first  (res_first)
    );

    typedef struct {
        logic [15:0] count;
        logic [15:0] first;
    } res_t;

    typedef struct {
        logic        v0;
        logic        v1;
        logic [7:0]  a0;
        logic        s0;
        logic [15:0] g0;
        logic [7:0]  a1;
        logic        s1;
        logic [15:0] g1;
        logic [1:0]  exp_grant;
    } wr_vec_t;

    int total = 0;
    int bad   = 0;

    cfg_bus_t bus_q[$];
    res_t     res_q[$];
    wr_vec_t  vec[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic cfg_bus_t nop_bus();
        cfg_bus_t b;
        b.addr = 8'hFF;
        b.cmd  = 8'(CMD_NOP);
        b.arg  = 16'h0000;
        return b;
    endfunction

    function automatic cfg_bus_t clear_bus();
        cfg_bus_t b;
        b.addr = 8'hFF;
        b.cmd  = 8'h00;
        b.arg  = 16'h0000;
        return b;
    endfunction

    function automatic cfg_bus_t wr_bus(input logic [7:0] a, input logic s, input logic [15:0] g);
        cfg_bus_t b;
        b.addr = a;
        b.cmd  = s ? 8'(CMD_W2) : 8'(CMD_W1);
        b.arg  = g;
        return b;
    endfunction

    task automatic check_bus(input string name);
        cfg_bus_t e;
        if (bus_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: bus scoreboard empty", name);
        end else begin
            e = bus_q.pop_front();
            chk(name, {bus_addr, bus_cmd, bus_arg}, e);
        end
    endtask

    // Starts at posedge+1 in IDLE with no pending writes; returns in IDLE.
    task automatic run_episode(input logic [15:0] len, input logic [31:0] mask, input logic spike_outside);
        int   n;
        res_t e;
        n = (len == 16'd0) ? 1 : int'(len);
        e.count = 16'd0;
        e.first = 16'hFFFF;
        for (int w = 0; w < n; w++) begin
            if (mask[w]) begin
                e.count++;
                if (e.first == 16'hFFFF) e.first = w[15:0];
            end
        end
        res_q.push_back(e);

        eval_valid = 1'b1;
        eval_len   = len;
        #1;
        chk("ep_eval_ready", eval_ready, 1);
        tick();
        eval_valid = 1'b0;
        eval_len   = 16'd3;
        for (int k = 0; k < NCLR; k++) begin
            net_out = spike_outside;
            bus_q.push_back(clear_bus());
            check_bus("ep_clear_bus");
            tick();
        end
        for (int w = 0; w < n; w++) begin
            bus_q.push_back(nop_bus());
            check_bus("ep_run_bus");
            chk("ep_run_no_res", res_valid, 0);
            net_out = mask[w];
            tick();
        end
        net_out = spike_outside;
        chk("ep_res_valid", res_valid, 1);
        e = res_q.pop_front();
        chk("ep_res_count", res_count, e.count);
        chk("ep_res_first", res_first, e.first);
        tick();
        tick();
        chk("ep_hold_valid", res_valid, 1);
        chk("ep_hold_count", res_count, e.count);
        chk("ep_hold_first", res_first, e.first);
        chk("ep_hold_eval_ready", eval_ready, 0);
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        net_out = 1'b0;
        chk("ep_ack_valid", res_valid, 0);
        chk("ep_ack_idle", eval_ready, 1);
    endtask

    initial begin
        // {v0, v1, a0, s0, g0, a1, s1, g1, expected grant}; pending port data is held.
        vec[0]  = '{1'b1, 1'b0, 8'd5,  1'b0, 16'd127,  8'h81, 1'b1, 16'hF001, 2'b01};
        vec[1]  = '{1'b1, 1'b0, 8'd5,  1'b0, 16'd127,  8'h81, 1'b1, 16'hF001, 2'b01};
        vec[2]  = '{1'b1, 1'b0, 8'd5,  1'b0, 16'd127,  8'h81, 1'b1, 16'hF001, 2'b01};
        vec[3]  = '{1'b0, 1'b0, 8'd5,  1'b0, 16'd127,  8'h81, 1'b1, 16'hF001, 2'b00};
        vec[4]  = '{1'b1, 1'b1, 8'h10, 1'b1, 16'h1234, 8'h90, 1'b0, 16'hFFFE, 2'b10};
        vec[5]  = '{1'b1, 1'b1, 8'h10, 1'b1, 16'h1234, 8'h91, 1'b1, 16'h8000, 2'b01};
        vec[6]  = '{1'b1, 1'b1, 8'h11, 1'b0, 16'h0001, 8'h91, 1'b1, 16'h8000, 2'b10};
        vec[7]  = '{1'b1, 1'b1, 8'h11, 1'b0, 16'h0001, 8'h92, 1'b0, 16'h0BB0, 2'b01};
        vec[8]  = '{1'b0, 1'b1, 8'h11, 1'b0, 16'h0001, 8'h92, 1'b0, 16'h0BB0, 2'b10};
        vec[9]  = '{1'b1, 1'b0, 8'h12, 1'b1, 16'h5555, 8'h92, 1'b0, 16'h0BB0, 2'b01};
        vec[10] = '{1'b0, 1'b0, 8'h12, 1'b1, 16'h5555, 8'h92, 1'b0, 16'h0BB0, 2'b00};

        // Reset state, with every request valid to show readies are held low.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        eval_valid = 1'b1;
        #12;
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_eval_ready", eval_ready, 0);
        chk("rst_bus", {bus_addr, bus_cmd, bus_arg}, nop_bus());
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_count", res_count, 16'h0000);
        chk("rst_res_first", res_first, 16'hFFFF);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        eval_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Write arbitration table.
        for (int i = 0; i < 11; i++) begin
            req0_valid = vec[i].v0;
            req0_addr  = vec[i].a0;
            req0_sel   = vec[i].s0;
            req0_arg   = vec[i].g0;
            req1_valid = vec[i].v1;
            req1_addr  = vec[i].a1;
            req1_sel   = vec[i].s1;
            req1_arg   = vec[i].g1;
            #1;
            chk("tbl_req0_ready", req0_ready, vec[i].exp_grant[0]);
            chk("tbl_req1_ready", req1_ready, vec[i].exp_grant[1]);
            chk("tbl_eval_ready", eval_ready, !(vec[i].v0 || vec[i].v1));
            if (vec[i].exp_grant[0])      bus_q.push_back(wr_bus(vec[i].a0, vec[i].s0, vec[i].g0));
            else if (vec[i].exp_grant[1]) bus_q.push_back(wr_bus(vec[i].a1, vec[i].s1, vec[i].g1));
            else                          bus_q.push_back(nop_bus());
            tick();
            check_bus("tbl_bus");
        end

        // Episodes: spikes at 3 and 7; no spikes; zero length means one cycle.
        run_episode(16'd10, 32'h0000_0088, 1'b1);
        run_episode(16'd5,  32'h0000_0000, 1'b0);
        run_episode(16'd0,  32'h0000_0001, 1'b1);

        // Pending write blocks an episode; then abort during RUN.
        req1_valid = 1'b1;
        req1_addr  = 8'h33;
        req1_sel   = 1'b1;
        req1_arg   = 16'hABCD;
        eval_valid = 1'b1;
        eval_len   = 16'd20;
        #1;
        chk("pend_req1_ready", req1_ready, 1);
        chk("pend_req0_ready", req0_ready, 0);
        chk("pend_eval_ready", eval_ready, 0);
        bus_q.push_back(wr_bus(8'h33, 1'b1, 16'hABCD));
        tick();
        check_bus("pend_bus");
        req1_valid = 1'b0;
        #1;
        chk("pend_eval_ready_after", eval_ready, 1);
        tick();
        eval_valid = 1'b0;
        for (int k = 0; k < NCLR; k++) begin
            bus_q.push_back(clear_bus());
            check_bus("abort_clear_bus");
            tick();
        end
        net_out = 1'b1;
        for (int w = 0; w < 5; w++) tick();
        abort = 1'b1;
        tick();
        abort   = 1'b0;
        net_out = 1'b0;
        chk("abort_idle", eval_ready, 1);
        bus_q.push_back(nop_bus());
        check_bus("abort_bus");
        begin
            logic seen;
            seen = 1'b0;
            for (int c = 0; c < 25; c++) begin
                if (res_valid) seen = 1'b1;
                tick();
            end
            chk("abort_no_res", seen, 0);
        end

        // Leave the pointer on port 1, then async reset in the middle of RUN.
        req0_valid = 1'b1;
        req0_addr  = 8'h44;
        req0_sel   = 1'b0;
        req0_arg   = 16'h0101;
        #1;
        chk("prerst_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        eval_valid = 1'b1;
        eval_len   = 16'd10;
        #1;
        chk("rstep_eval_ready", eval_ready, 1);
        tick();
        eval_valid = 1'b0;
        for (int k = 0; k < NCLR + 4; k++) tick();
        net_out = 1'b1;
        #2;
        rst = 1'b1;
        req0_valid = 1'b1;
        #1;
        chk("midrst_bus", {bus_addr, bus_cmd, bus_arg}, nop_bus());
        chk("midrst_req0_ready", req0_ready, 0);
        chk("midrst_res_valid", res_valid, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        net_out = 1'b0;
        req0_valid = 1'b1;
        req0_addr  = 8'h55;
        req0_sel   = 1'b1;
        req0_arg   = 16'h0202;
        req1_valid = 1'b1;
        req1_addr  = 8'h66;
        req1_sel   = 1'b0;
        req1_arg   = 16'h0303;
        #1;
        chk("postrst_req0_ready", req0_ready, 1);
        chk("postrst_req1_ready", req1_ready, 0);
        bus_q.push_back(wr_bus(8'h55, 1'b1, 16'h0202));
        @(posedge clk);
        #1;
        check_bus("postrst_bus0");
        req0_valid = 1'b0;
        #1;
        chk("postrst_req1_ready2", req1_ready, 1);
        bus_q.push_back(wr_bus(8'h66, 1'b0, 16'h0303));
        tick();
        check_bus("postrst_bus1");
        req1_valid = 1'b0;
        run_episode(16'd6, 32'h0000_0021, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
